// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single sram_ctl: port 0 = instruction fetch, port 1 = data.
// Define SRAM_ARB_RR_EN for round-robin contention; default build gives port 1 fixed priority.
module sram_arbiter #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              m0_req_i,
   input  logic              m0_rw_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_ack_o,

   input  logic              m1_req_i,
   input  logic              m1_rw_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_ack_o,

   output logic              ctl_start_o,
   output logic              ctl_rw_o,
   output logic [ADDR_W-1:0] ctl_addr_o,
   output logic [DATA_W-1:0] ctl_data_o,
   output logic [DATA_W/8-1:0] ctl_be_o,
   input  logic [DATA_W-1:0] ctl_data_i,
   input  logic              ctl_r_ready_i,
   input  logic              ctl_w_finish_i,
   input  logic              ctl_busy_i,

   output logic              owner_o,
   output logic              busy_o
);

   localparam int unsigned BE_W = DATA_W / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              start_q, start_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              grant_c;
   logic              done_c;

   // Winner selection; only meaningful when at least one port requests
   always_comb begin
      grant_c = m1_req_i;
      if (m0_req_i && m1_req_i) begin
`ifdef SRAM_ARB_RR_EN
         grant_c = ~last_grant_q;
`else
         grant_c = 1'b1;
`endif
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      start_d      = 1'b0;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      done_c       = rw_q ? ctl_r_ready_i : ctl_w_finish_i;

      case (state_q)
         S_IDLE: begin
            if (!ctl_busy_i && (m0_req_i || m1_req_i)) begin
               owner_d = grant_c;
               start_d = 1'b1;
               state_d = S_ISSUE;
               if (grant_c) begin
                  rw_d    = m1_rw_i;
                  addr_d  = m1_addr_i;
                  wdata_d = m1_wdata_i;
                  be_d    = m1_be_i;
               end else begin
                  rw_d    = m0_rw_i;
                  addr_d  = m0_addr_i;
                  wdata_d = m0_wdata_i;
                  be_d    = m0_be_i;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (done_c) begin
               state_d = S_DONE;
               ack0_d  = ~owner_q;
               ack1_d  = owner_q;
               if (rw_q && !owner_q) rdata0_d = ctl_data_i;
               if (rw_q &&  owner_q) rdata1_d = ctl_data_i;
            end
         end
         S_DONE: begin
            last_grant_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
      end
   end

   assign ctl_start_o = start_q;
   assign ctl_rw_o    = rw_q;
   assign ctl_addr_o  = addr_q;
   assign ctl_data_o  = wdata_q;
   assign ctl_be_o    = be_q;
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;
   assign m0_ack_o    = ack0_q;
   assign m1_ack_o    = ack1_q;
   assign owner_o     = owner_q;
   assign busy_o      = busy_q;

endmodule
